// File: rtl/lc3b_writeback_buffer.sv
// lc3b_writeback_buffer: FIFO write-back buffer between the L1 D-cache and memory.
// Dirty victims are queued in one cycle, drained one line at a time, and remain
// visible to a combinational lookup until popped.
// Optional macro LC3B_WBUF_COALESCE_EN: an eviction that matches a queued line
// (other than the head currently being written) overwrites it in place.
module lc3b_writeback_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter int unsigned LINE_W   = 128,
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned OFFSET_W = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       evict_valid,
    output logic                       evict_ready,
    input  logic [ADDR_W-OFFSET_W-1:0] evict_addr,
    input  logic [LINE_W-1:0]          evict_data,
    input  logic [ADDR_W-OFFSET_W-1:0] lookup_addr,
    output logic                       lookup_hit,
    output logic [LINE_W-1:0]          lookup_data,
    output logic                       mem_write,
    output logic [ADDR_W-1:0]          mem_address,
    output logic [LINE_W-1:0]          mem_wdata,
    input  logic                       mem_resp,
    output logic                       empty
);

    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned LADDR_W = ADDR_W - OFFSET_W;

    typedef enum logic [0:0] {StIdle, StWrite} state_e;

    state_e               state_q;
    logic                 mem_write_q;
    logic [PTR_W-1:0]     wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]     count_q;
    logic [LADDR_W-1:0]   addr_q [DEPTH];
    logic [LINE_W-1:0]    data_q [DEPTH];

    logic                 accept, push, pop;
    logic                 coal_hit;
    logic [PTR_W-1:0]     coal_idx;
    logic [PTR_W-1:0]     lk_idx;

    // reset term keeps the handshake closed while reset is held
    assign evict_ready = ~reset & (count_q < CNT_W'(DEPTH));
    assign accept      = evict_valid & evict_ready;
    assign pop         = (state_q == StWrite) & mem_resp;
    assign push        = accept & ~coal_hit;

    assign mem_write   = mem_write_q;
    assign mem_address = {addr_q[rd_ptr_q], {OFFSET_W{1'b0}}};
    assign mem_wdata   = data_q[rd_ptr_q];
    assign empty       = (count_q == '0) & (state_q == StIdle);

    // Lookup: scan oldest to newest so the newest match is the one left standing
    always_comb begin
        lookup_hit  = 1'b0;
        lookup_data = '0;
        lk_idx      = '0;
        for (int k = 0; k < DEPTH; k++) begin
            lk_idx = rd_ptr_q + PTR_W'(k);
            if ((CNT_W'(k) < count_q) && (addr_q[lk_idx] == lookup_addr)) begin
                lookup_hit  = 1'b1;
                lookup_data = data_q[lk_idx];
            end
        end
    end

    // Coalescing target search; the head is off-limits while it is on the bus
    always_comb begin
        coal_hit = 1'b0;
        coal_idx = '0;
`ifdef LC3B_WBUF_COALESCE_EN
        for (int k = 0; k < DEPTH; k++) begin
            if ((CNT_W'(k) < count_q) &&
                (addr_q[rd_ptr_q + PTR_W'(k)] == evict_addr) &&
                !((k == 0) && (state_q == StWrite))) begin
                coal_hit = 1'b1;
                coal_idx = rd_ptr_q + PTR_W'(k);
            end
        end
`endif
    end

    // Line storage: append at the write pointer or overwrite a coalesced entry
    always_ff @(posedge clk) begin
        if (push) begin
            addr_q[wr_ptr_q] <= evict_addr;
            data_q[wr_ptr_q] <= evict_data;
        end else if (accept) begin
            data_q[coal_idx] <= evict_data;
        end
    end

    // Pointers and occupancy; pointer width makes wrap modulo DEPTH implicit
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            count_q <= count_q + CNT_W'(push) - CNT_W'(pop);
        end
    end

    // Drain FSM with registered mem_write; the return to idle forces one bubble
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            mem_write_q <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (count_q != '0) begin
                        state_q     <= StWrite;
                        mem_write_q <= 1'b1;
                    end
                end
                StWrite: begin
                    if (mem_resp) begin
                        state_q     <= StIdle;
                        mem_write_q <= 1'b0;
                    end
                end
                default: begin
                    state_q     <= StIdle;
                    mem_write_q <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lc3b_writeback_buffer.sv
// Randomised bench for lc3b_writeback_buffer against a queue-based reference model.
module tb_lc3b_writeback_buffer;

    localparam int unsigned DEPTH    = 4;
    localparam int unsigned LINE_W   = 128;
    localparam int unsigned ADDR_W   = 16;
    localparam int unsigned OFFSET_W = 4;
    localparam int unsigned LA_W     = ADDR_W - OFFSET_W;

    logic              clk = 1'b0;
    logic              reset;
    logic              evict_valid;
    logic              evict_ready;
    logic [LA_W-1:0]   evict_addr;
    logic [LINE_W-1:0] evict_data;
    logic [LA_W-1:0]   lookup_addr;
    logic              lookup_hit;
    logic [LINE_W-1:0] lookup_data;
    logic              mem_write;
    logic [ADDR_W-1:0] mem_address;
    logic [LINE_W-1:0] mem_wdata;
    logic              mem_resp;
    logic              empty;

    lc3b_writeback_buffer #(
        .DEPTH    (DEPTH),
        .LINE_W   (LINE_W),
        .ADDR_W   (ADDR_W),
        .OFFSET_W (OFFSET_W)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .evict_valid (evict_valid),
        .evict_ready (evict_ready),
        .evict_addr  (evict_addr),
        .evict_data  (evict_data),
        .lookup_addr (lookup_addr),
        .lookup_hit  (lookup_hit),
        .lookup_data (lookup_data),
        .mem_write   (mem_write),
        .mem_address (mem_address),
        .mem_wdata   (mem_wdata),
        .mem_resp    (mem_resp),
        .empty       (empty)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [LA_W-1:0]   addr;
        logic [LINE_W-1:0] data;
    } ent_t;

    ent_t mq[$];       // queued lines, oldest first
    bit   m_writing;   // a memory write is being presented

    int n_chk = 0;
    int n_err = 0;

    task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [LINE_W-1:0] rnd_line();
        return {$urandom(), $urandom(), $urandom(), $urandom()};
    endfunction

    // One clock: drive at negedge, check model outputs, then advance model at posedge
    task automatic cycle(input logic v, input logic [LA_W-1:0] a, input logic [LINE_W-1:0] d,
                         input logic [LA_W-1:0] la, input logic r);
        int   n;
        bit   acc, pp, co, hit;
        ent_t e;
        logic [LINE_W-1:0] ldata;
        @(negedge clk);
        evict_valid = v;
        evict_addr  = a;
        evict_data  = d;
        lookup_addr = la;
        mem_resp    = r;
        #1;
        n     = mq.size();
        hit   = 1'b0;
        ldata = '0;
        foreach (mq[i]) if (mq[i].addr == la) begin
            hit   = 1'b1;
            ldata = mq[i].data;
        end
        check_eq("evict_ready", 128'(evict_ready), 128'(n < DEPTH));
        check_eq("mem_write",   128'(mem_write),   128'(m_writing));
        check_eq("empty",       128'(empty),       128'((n == 0) && !m_writing));
        check_eq("lookup_hit",  128'(lookup_hit),  128'(hit));
        check_eq("lookup_data", lookup_data,       ldata);
        check_eq("addr_lsb",    128'(mem_address[OFFSET_W-1:0]), 128'(0));
        if (m_writing && n > 0) begin
            check_eq("mem_address", 128'(mem_address), 128'({mq[0].addr, 4'h0}));
            check_eq("mem_wdata",   mem_wdata,         mq[0].data);
        end
        @(posedge clk);
        acc = v && (n < DEPTH);
        pp  = m_writing && r;
        co  = 1'b0;
`ifdef LC3B_WBUF_COALESCE_EN
        if (acc) begin
            for (int i = n - 1; i >= 0; i--) begin
                if (mq[i].addr == a && !(i == 0 && m_writing)) begin
                    mq[i].data = d;
                    co = 1'b1;
                    break;
                end
            end
        end
`endif
        if (pp) mq.delete(0);
        if (acc && !co) begin
            e.addr = a;
            e.data = d;
            mq.push_back(e);
        end
        m_writing = m_writing ? !r : (n > 0);
    endtask

    task automatic idle(input int cycles, input logic [LA_W-1:0] la);
        for (int i = 0; i < cycles; i++) cycle(1'b0, '0, '0, la, 1'b0);
    endtask

    task automatic model_clear();
        mq.delete();
        m_writing = 1'b0;
    endtask

    logic [LINE_W-1:0] d1, d2, d3;

    initial begin
        reset = 1'b1;
        evict_valid = 1'b0;
        evict_addr  = '0;
        evict_data  = '0;
        lookup_addr = '0;
        mem_resp    = 1'b0;
        model_clear();
        repeat (2) @(negedge clk);
        evict_valid = 1'b1;
        #1;
        check_eq("rst_evict_ready", 128'(evict_ready), 128'(0));
        check_eq("rst_mem_write",   128'(mem_write),   128'(0));
        check_eq("rst_empty",       128'(empty),       128'(1));
        evict_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Single line: latency, address formation, completion
        d1 = rnd_line();
        cycle(1'b1, 12'h0A5, d1, 12'h0A5, 1'b0);
        idle(3, 12'h0A5);
        cycle(1'b0, '0, '0, 12'h0A5, 1'b1);
        idle(2, 12'h0A5);

        // Fill to DEPTH without responses, then one response, then drain
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, LA_W'(12'h100 + i), rnd_line(), 12'h101, 1'b0);
        cycle(1'b0, '0, '0, 12'h102, 1'b1);
        idle(1, 12'h100);
        // Full with evict held and a response in the same cycle
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, LA_W'(12'h100 + i), rnd_line(), 12'h103, 1'b0);
        d2 = rnd_line();
        cycle(1'b1, 12'h1F0, d2, 12'h1F0, 1'b1);
        cycle(1'b1, 12'h1F0, d2, 12'h1F0, 1'b0);
        for (int i = 0; i < 12; i++) cycle(1'b0, '0, '0, 12'h1F0, (i % 3) == 2);

        // Lookup hits, newest data, and a miss
        model_clear();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        d1 = rnd_line();
        d2 = rnd_line();
        d3 = rnd_line();
        cycle(1'b1, 12'h011, d1, 12'h022, 1'b0);
        cycle(1'b1, 12'h022, d2, 12'h022, 1'b0);
        cycle(1'b0, '0, '0, 12'h022, 1'b0);
        cycle(1'b0, '0, '0, 12'h033, 1'b0);
        // Head 0x011 on the bus; a second 0x022 coalesces or appends
        cycle(1'b1, 12'h022, d3, 12'h022, 1'b0);
        cycle(1'b0, '0, '0, 12'h022, 1'b0);
        for (int i = 0; i < 12; i++) cycle(1'b0, '0, '0, 12'h022, (i % 3) == 1);

        // Asynchronous reset during a write with three entries
        for (int i = 0; i < 3; i++) cycle(1'b1, LA_W'(12'h200 + i), rnd_line(), 12'h200, 1'b0);
        idle(2, 12'h200);
        check_eq("pre_reset_writing", 128'(mem_write), 128'(1));
        @(negedge clk);
        #2 reset = 1'b1;
        #1;
        check_eq("async_mem_write", 128'(mem_write),   128'(0));
        check_eq("async_empty",     128'(empty),       128'(1));
        check_eq("async_ready",     128'(evict_ready), 128'(0));
        model_clear();
        @(negedge clk);
        reset = 1'b0;
        cycle(1'b0, '0, '0, 12'h200, 1'b1);
        idle(3, 12'h201);

        // Randomised traffic over a small address set to force duplicates
        for (int i = 0; i < 800; i++) begin
            logic [LA_W-1:0] ea, la;
            ea = LA_W'(12'h300 + $urandom_range(0, 5));
            la = ($urandom_range(0, 3) == 0) ? LA_W'($urandom()) : LA_W'(12'h300 + $urandom_range(0, 5));
            cycle($urandom_range(0, 1) == 1, ea, rnd_line(), la, $urandom_range(0, 2) == 0);
        end
        for (int i = 0; i < 20; i++) cycle(1'b0, '0, '0, 12'h300, (i % 2) == 1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
